// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models a fixed
// multi-cycle latency and publishes busy so younger MDU ops and mfhi/mflo stall.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_mdu_op,
  input  logic        i_start,
  input  logic        i_req,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic [31:0] o_rd_data
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

  typedef enum logic {StIdle, StRun} state_e;

  state_e      r_state;
  logic [3:0]  r_count;
  logic        r_busy;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_pend_hi, r_pend_lo;

  logic        w_is_muldiv, w_is_div, w_signed_div, w_accept, w_mt_ok;
  logic [63:0] w_mul_s, w_mul_u;
  logic        w_rs_neg, w_rt_neg, w_div_zero;
  logic [31:0] w_dvd, w_dvs, w_uq, w_ur, w_q, w_r;
  logic [31:0] w_res_hi, w_res_lo;

  assign w_is_muldiv  = (i_mdu_op >= OpMult) && (i_mdu_op <= OpDivu);
  assign w_is_div     = (i_mdu_op == OpDiv) || (i_mdu_op == OpDivu);
  assign w_signed_div = (i_mdu_op == OpDiv);
  assign w_accept     = (r_state == StIdle) && i_start && w_is_muldiv && !i_req;
  assign w_mt_ok      = (r_state == StIdle) && !i_req;

  // Full-width products; operands pre-extended so no width promotion surprises.
  assign w_mul_s = $signed({{32{i_rs_data[31]}}, i_rs_data}) *
                   $signed({{32{i_rt_data[31]}}, i_rt_data});
  assign w_mul_u = {32'd0, i_rs_data} * {32'd0, i_rt_data};

  // Signed divide done on magnitudes so 0x80000000 / -1 cannot overflow.
  assign w_rs_neg   = w_signed_div && i_rs_data[31];
  assign w_rt_neg   = w_signed_div && i_rt_data[31];
  assign w_dvd      = w_rs_neg ? (32'd0 - i_rs_data) : i_rs_data;
  assign w_dvs      = w_rt_neg ? (32'd0 - i_rt_data) : i_rt_data;
  assign w_div_zero = (i_rt_data == 32'd0);
  assign w_uq       = w_div_zero ? 32'd0 : (w_dvd / w_dvs);
  assign w_ur       = w_div_zero ? 32'd0 : (w_dvd % w_dvs);
  assign w_q        = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_uq) : w_uq;
  assign w_r        = w_rs_neg ? (32'd0 - w_ur) : w_ur;

  // Select the result that will be parked in the pending registers on accept.
  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    if (i_mdu_op == OpMult) begin
      w_res_hi = w_mul_s[63:32];
      w_res_lo = w_mul_s[31:0];
    end else if (i_mdu_op == OpMultu) begin
      w_res_hi = w_mul_u[63:32];
      w_res_lo = w_mul_u[31:0];
    end else if (w_is_div && !w_div_zero) begin
      // Divide by zero keeps the current HI/LO as the "result".
      w_res_hi = w_r;
      w_res_lo = w_q;
    end
  end

  // Single sequencer: IDLE accepts ops and mt writes, RUN counts down to commit.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= StIdle;
      r_count   <= 4'd0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_count   <= w_is_div ? DivLoad : MultLoad;
            r_busy    <= 1'b1;
            r_state   <= StRun;
          end else if (w_mt_ok && (i_mdu_op == OpMthi)) begin
            r_hi <= i_rs_data;
          end else if (w_mt_ok && (i_mdu_op == OpMtlo)) begin
            r_lo <= i_rs_data;
          end
        end
        StRun: begin
          // req does not cancel an in-flight op; only the count matters here.
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // mfhi/mflo read path: always the architectural value, even while busy.
  always_comb begin
    o_rd_data = 32'd0;
    if (i_mdu_op == OpMfhi) o_rd_data = r_hi;
    else if (i_mdu_op == OpMflo) o_rd_data = r_lo;
  end

  assign o_busy = r_busy;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: table of ops checked through a result scoreboard,
// plus hand sequences for cancellation, mid-run events and mid-run reset.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic        start = 1'b0;
  logic        req = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        busy;
  logic [31:0] hi, lo, rd_data;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs, rt, hi, lo;
    int          cyc;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    int          cyc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_mdu_op  (mdu_op),
    .i_start   (start),
    .i_req     (req),
    .i_rs_data (rs_data),
    .i_rt_data (rt_data),
    .o_busy    (busy),
    .o_hi      (hi),
    .o_lo      (lo),
    .o_rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  // mthi (5) / mtlo (6) in IDLE; busy must stay low.
  task automatic mt(input logic [3:0] op, input logic [31:0] val);
    @(negedge clk);
    mdu_op = op; rs_data = val;
    @(negedge clk);
    mdu_op = 4'd0;
    check(op == 4'd5 ? "mthi" : "mtlo", op == 4'd5 ? hi : lo, val);
    check("mt busy", {31'd0, busy}, 32'd0);
  endtask

  // Issue one op, push its expectation, then pop it when busy falls.
  task automatic run_op(input vec_t v);
    exp_t e, got;
    int   cyc;
    e.hi = v.hi; e.lo = v.lo; e.cyc = v.cyc;
    sb.push_back(e);
    @(negedge clk);
    mdu_op = v.op; start = 1'b1; rs_data = v.rs; rt_data = v.rt;
    @(negedge clk);
    mdu_op = 4'd0; start = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    got = sb.pop_front();
    check({v.name, " busy cycles"}, 32'(cyc), 32'(got.cyc));
    check({v.name, " hi"}, hi, got.hi);
    check({v.name, " lo"}, lo, got.lo);
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] rs, rt, h, l,
                              input int cyc, input string name);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.hi = h; v.lo = l; v.cyc = cyc; v.name = name;
    return v;
  endfunction

  initial begin
    logic [31:0] a, b;
    logic [63:0] p;
    exp_t        e, got;

    vecs.push_back(mk(4'd1, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, "mult"));
    vecs.push_back(mk(4'd2, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 5, "multu"));
    vecs.push_back(mk(4'd3, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div -7/2"));
    vecs.push_back(mk(4'd3, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 10, "div 7/-2"));
    vecs.push_back(mk(4'd4, 32'h7, 32'h2, 32'h1, 32'h3, 10, "divu 7/2"));
    vecs.push_back(mk(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10, "div ovf"));
    vecs.push_back(mk(4'd3, 32'h1234, 32'h0, 32'hA, 32'hB, 10, "div by 0"));
    vecs.push_back(mk(4'd4, 32'h1234, 32'h0, 32'hA, 32'hB, 10, "divu by 0"));
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      p = {32'd0, a} * {32'd0, b};
      vecs.push_back(mk(4'd2, a, b, p[63:32], p[31:0], 5, "rand multu"));
      b = b >> $urandom_range(0, 28);
      if (b == 32'd0) b = 32'd3;
      vecs.push_back(mk(4'd4, a, b, a % b, a / b, 10, "rand divu"));
    end

    // Reset held for 3 cycles.
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b1;

    mt(4'd5, 32'h12345678);
    mt(4'd6, 32'h9ABCDEF0);
    check("hi after mtlo", hi, 32'h12345678);

    // Table: every op starts from HI=0xA, LO=0xB (matters for divide by zero).
    foreach (vecs[i]) begin
      mt(4'd5, 32'hA);
      mt(4'd6, 32'hB);
      run_op(vecs[i]);
    end

    // Cancellation: start with req in the same cycle must not accept.
    mt(4'd5, 32'hA);
    mt(4'd6, 32'hB);
    @(negedge clk);
    mdu_op = 4'd1; start = 1'b1; req = 1'b1; rs_data = 32'd3; rt_data = 32'd5;
    @(negedge clk);
    mdu_op = 4'd5; start = 1'b0; rs_data = 32'hBAD0; // mthi with req also blocked
    @(negedge clk);
    mdu_op = 4'd0; req = 1'b0;
    repeat (2) begin
      check("req cancel busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    check("req cancel hi", hi, 32'hA);
    check("req cancel lo", lo, 32'hB);

    // Mult 3*5 with mflo, mthi, start and req arriving while it runs.
    e.hi = 32'd0; e.lo = 32'd15; e.cyc = 5;
    sb.push_back(e);
    @(negedge clk);
    mdu_op = 4'd1; start = 1'b1; rs_data = 32'd3; rt_data = 32'd5;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("run busy", {31'd0, busy}, 32'd1);
      mdu_op = 4'd0; start = 1'b0; req = 1'b0;
      case (i)
        1: begin mdu_op = 4'd8; #1 check("mflo in run", rd_data, 32'hB); end
        2: begin mdu_op = 4'd5; rs_data = 32'hDEAD; end
        3: req = 1'b1;
        4: begin mdu_op = 4'd3; start = 1'b1; rs_data = 32'd100; rt_data = 32'd7; end
        default: begin mdu_op = 4'd7; #1 check("mfhi in run", rd_data, 32'hA); end
      endcase
    end
    @(negedge clk);
    mdu_op = 4'd0; start = 1'b0; req = 1'b0;
    got = sb.pop_front();
    check("mid-run busy done", {31'd0, busy}, 32'd0);
    check("mid-run hi", hi, got.hi);
    check("mid-run lo", lo, got.lo);
    @(negedge clk);
    check("no second op", {31'd0, busy}, 32'd0);
    mdu_op = 4'd8;
    #1 check("mflo idle", rd_data, 32'd15);
    mdu_op = 4'd0;

    // Reset at cycle 2 of a div discards the pending result.
    @(negedge clk);
    mdu_op = 4'd4; start = 1'b1; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    mdu_op = 4'd0; start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst mid busy", {31'd0, busy}, 32'd0);
    check("rst mid hi", hi, 32'd0);
    check("rst mid lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || lo !== 32'd0) begin
        check("no late result", {31'd0, busy} | lo, 32'd0);
        break;
      end
    end
    check("after rst hi", hi, 32'd0);
    check("after rst lo", lo, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
